// File: rtl/dcache_refill_ctrl_if.sv
// Miss, memory-read and cache-fill signals of the data-cache refill engine.
// The controller takes the master modport; the LSU, memory and cache take the slave side.
interface dcache_refill_ctrl_if #(
  parameter int BLOCK_SIZE = 128
);
  logic                  miss_valid;
  logic                  miss_ready;
  logic [31:0]           miss_addr;
  logic                  miss_is_store;
  logic [31:0]           miss_store_data;
  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic [31:0]           mem_req_addr;
  logic                  mem_resp_valid;
  logic [31:0]           mem_resp_data;
  logic                  cache_w_en;
  logic                  cache_is_repair;
  logic [31:0]           cache_w_addr;
  logic [31:0]           cache_w_data;
  logic [BLOCK_SIZE-1:0] cache_repair_data;
  logic                  busy;
  logic                  done;

  modport master (
    input  miss_valid, miss_addr, miss_is_store, miss_store_data,
    input  mem_req_ready, mem_resp_valid, mem_resp_data,
    output miss_ready, mem_req_valid, mem_req_addr,
    output cache_w_en, cache_is_repair, cache_w_addr, cache_w_data, cache_repair_data,
    output busy, done
  );

  modport slave (
    output miss_valid, miss_addr, miss_is_store, miss_store_data,
    output mem_req_ready, mem_resp_valid, mem_resp_data,
    input  miss_ready, mem_req_valid, mem_req_addr,
    input  cache_w_en, cache_is_repair, cache_w_addr, cache_w_data, cache_repair_data,
    input  busy, done
  );
endinterface

// File: rtl/dcache_refill_ctrl.sv
// Single-miss refill engine: fetches a block word by word, fills the cache, replays store misses.
// Load miss done_o after 2*WORDS+2 cycles minimum (+1 for stores); stalls freely on mem ready/resp.
module dcache_refill_ctrl #(
  parameter int BLOCK_SIZE = 128
) (
  input logic                 clk,
  input logic                 rst_n,
  dcache_refill_ctrl_if.master bus
);
  localparam int WORDS    = BLOCK_SIZE / 32;
  localparam int OFF_BITS = $clog2(WORDS);
  localparam logic [OFF_BITS-1:0] LAST = OFF_BITS'(WORDS - 1);

  typedef enum logic [2:0] {IDLE, REQ, RESP, FILL, STORE, DONE} state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        is_store;
    logic [31:0] data;
  } miss_t;

  state_t                state;
  miss_t                 miss_q;
  logic [OFF_BITS-1:0]   cnt;
  logic [OFF_BITS-1:0]   cnt_inc;
  logic [BLOCK_SIZE-1:0] blk;
  logic [BLOCK_SIZE-1:0] blk_next;

  assign cnt_inc = cnt + OFF_BITS'(1);

  // Block with the incoming word merged, so the last word can go straight into the fill.
  always_comb begin
    blk_next = blk;
    blk_next[32*cnt +: 32] = bus.mem_resp_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                 <= IDLE;
      miss_q                <= '0;
      cnt                   <= '0;
      blk                   <= '0;
      bus.miss_ready        <= 1'b1;
      bus.mem_req_valid     <= 1'b0;
      bus.mem_req_addr      <= '0;
      bus.cache_w_en        <= 1'b0;
      bus.cache_is_repair   <= 1'b0;
      bus.cache_w_addr      <= '0;
      bus.cache_w_data      <= '0;
      bus.cache_repair_data <= '0;
      bus.busy              <= 1'b0;
      bus.done              <= 1'b0;
    end else begin
      bus.done              <= 1'b0;
      bus.cache_w_en        <= 1'b0;
      bus.cache_is_repair   <= 1'b0;
      bus.cache_w_addr      <= '0;
      bus.cache_w_data      <= '0;
      bus.cache_repair_data <= '0;
      case (state)
        IDLE: begin
          if (bus.miss_valid && bus.miss_ready) begin
            miss_q            <= '{addr: bus.miss_addr, is_store: bus.miss_is_store,
                                   data: bus.miss_store_data};
            cnt               <= '0;
            state             <= REQ;
            bus.miss_ready    <= 1'b0;
            bus.busy          <= 1'b1;
            bus.mem_req_valid <= 1'b1;
            bus.mem_req_addr  <= {bus.miss_addr[31:OFF_BITS+2], {OFF_BITS{1'b0}}, 2'b00};
          end
        end
        REQ: begin
          if (bus.mem_req_ready) begin
            bus.mem_req_valid <= 1'b0;
            state             <= RESP;
          end
        end
        RESP: begin
          if (bus.mem_resp_valid) begin
            blk <= blk_next;
            if (cnt == LAST) begin
              state                 <= FILL;
              bus.cache_w_en        <= 1'b1;
              bus.cache_is_repair   <= 1'b1;
              bus.cache_w_addr      <= miss_q.addr;
              bus.cache_repair_data <= blk_next;
            end else begin
              cnt               <= cnt_inc;
              state             <= REQ;
              bus.mem_req_valid <= 1'b1;
              bus.mem_req_addr  <= {miss_q.addr[31:OFF_BITS+2], cnt_inc, 2'b00};
            end
          end
        end
        FILL: begin
          if (miss_q.is_store) begin
            state            <= STORE;
            bus.cache_w_en   <= 1'b1;
            bus.cache_w_addr <= miss_q.addr;
            bus.cache_w_data <= miss_q.data;
          end else begin
            state    <= DONE;
            bus.done <= 1'b1;
          end
        end
        STORE: begin
          state    <= DONE;
          bus.done <= 1'b1;
        end
        DONE: begin
          state          <= IDLE;
          bus.busy       <= 1'b0;
          bus.miss_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dcache_refill_ctrl.sv
// Directed plus randomized bench for dcache_refill_ctrl against a word-addressed memory model.
// Latency is counted in rising edges after acceptance up to the first edge that samples done_o high.
module tb_dcache_refill_ctrl;
  localparam int BS  = 128;
  localparam int W   = BS / 32;
  localparam int OVW = 102 + BS;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dcache_refill_ctrl_if #(.BLOCK_SIZE(BS)) bus();
  dcache_refill_ctrl #(.BLOCK_SIZE(BS)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    int          k;
    logic        rep;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [BS-1:0] rd;
  } wr_t;

  int            n_assert = 0;
  int            n_fail   = 0;
  logic [31:0]   mem [logic [31:0]];
  wr_t           wrs [$];
  logic [31:0]   reqs [$];
  int            lat, acc_wait;
  bit            busy_bad, cache_bad, stall_bad, aborted;
  logic [255:0]  rst_vec;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (!mem.exists(a)) mem[a] = $urandom;
    return mem[a];
  endfunction

  function automatic logic [31:0] base_of(input logic [31:0] a);
    return a & ~32'(W * 4 - 1);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % W);
  endfunction

  function automatic logic [BS-1:0] exp_block(input logic [31:0] a);
    logic [BS-1:0] b;
    b = '0;
    for (int i = 0; i < W; i++) b[i*32 +: 32] = mem_rd(base_of(a) + 32'(4 * i));
    return b;
  endfunction

  function automatic logic [255:0] out_vec();
    return 256'({bus.miss_ready, bus.mem_req_valid, bus.mem_req_addr, bus.cache_w_en,
                 bus.cache_is_repair, bus.cache_w_addr, bus.cache_w_data,
                 bus.cache_repair_data, bus.busy, bus.done});
  endfunction

  // Drives one miss and plays memory; called at a falling edge.
  task automatic do_miss(input logic [31:0] a, input bit st, input logic [31:0] sd,
                         input int stall_word, input int stall_n, input int rdly,
                         input bit spur, input bit hold_en, input logic [31:0] hold_addr,
                         input int abort_word);
    bit outstanding, spur_done, stalled;
    int owait, stall_left;
    logic [31:0] oaddr, stall_addr;
    wr_t w;
    wrs.delete(); reqs.delete();
    busy_bad = 0; cache_bad = 0; stall_bad = 0; aborted = 0;
    lat = -1; acc_wait = 0;
    outstanding = 0; spur_done = 0; stalled = 0; owait = 0;
    stall_left = stall_n; oaddr = '0; stall_addr = '0;
    bus.miss_addr = a; bus.miss_is_store = st; bus.miss_store_data = sd; bus.miss_valid = 1'b1;
    while (bus.miss_ready !== 1'b1 && acc_wait < 50) begin
      @(negedge clk);
      acc_wait++;
    end
    @(posedge clk);
    #1;
    bus.miss_valid = hold_en;
    if (hold_en) begin
      bus.miss_addr = hold_addr; bus.miss_is_store = 1'b0; bus.miss_store_data = $urandom;
    end
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (abort_word >= 0 && outstanding && widx(oaddr) == abort_word) begin
        #2 rst_n = 1'b0;
        aborted = 1;
        break;
      end
      if (bus.done === 1'b1) begin
        lat = k + 1;
        bus.mem_resp_valid = 1'b0;
        bus.mem_req_ready = 1'b1;
        break;
      end
      if (bus.busy !== 1'b1 || bus.miss_ready !== 1'b0) busy_bad = 1;
      if (bus.cache_w_en === 1'b1) begin
        w.k = k; w.rep = bus.cache_is_repair; w.addr = bus.cache_w_addr;
        w.wd = bus.cache_w_data; w.rd = bus.cache_repair_data;
        wrs.push_back(w);
      end else if ({bus.cache_is_repair, bus.cache_w_addr, bus.cache_w_data,
                    bus.cache_repair_data} !== '0) begin
        cache_bad = 1;
      end
      bus.mem_resp_valid = 1'b0;
      bus.mem_resp_data  = '0;
      if (outstanding) begin
        if (owait == 0) begin
          bus.mem_resp_valid = 1'b1;
          bus.mem_resp_data  = mem_rd(oaddr);
          outstanding = 0;
        end else owait--;
      end else if (spur && !spur_done && bus.mem_req_valid === 1'b1) begin
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = 32'hBAD0_0000 | 32'($urandom_range(0, 16'hFFFF));
        spur_done = 1;
      end
      bus.mem_req_ready = 1'b1;
      if (bus.mem_req_valid === 1'b1) begin
        if (stalled && bus.mem_req_addr !== stall_addr) stall_bad = 1;
        if (stall_left > 0 && widx(bus.mem_req_addr) == stall_word) begin
          bus.mem_req_ready = 1'b0;
          stall_left--;
          stalled = 1;
          stall_addr = bus.mem_req_addr;
        end else begin
          reqs.push_back(bus.mem_req_addr);
          outstanding = 1;
          owait = rdly - 1;
          oaddr = bus.mem_req_addr;
          stalled = 0;
        end
      end
    end
  endtask

  task automatic check_miss(input string tag, input logic [31:0] a, input bit st,
                            input logic [31:0] sd, input int stall_n, input int rdly);
    bit req_ok;
    int exp_lat;
    exp_lat = 2 * W + 2 + int'(st) + stall_n + W * (rdly - 1);
    chk({tag, ".latency"}, 256'(lat), 256'(exp_lat));
    chk({tag, ".req_count"}, 256'(reqs.size()), 256'(W));
    req_ok = (reqs.size() == W);
    foreach (reqs[i]) if (reqs[i] !== base_of(a) + 32'(4 * i)) req_ok = 0;
    chk({tag, ".req_order"}, 256'(req_ok), 256'(1));
    chk({tag, ".write_count"}, 256'(wrs.size()), 256'(1 + int'(st)));
    if (wrs.size() >= 1) begin
      chk({tag, ".fill_repair"}, 256'(wrs[0].rep), 256'(1));
      chk({tag, ".fill_addr"}, 256'(wrs[0].addr), 256'(a));
      chk({tag, ".fill_data"}, 256'(wrs[0].rd), 256'(exp_block(a)));
    end
    if (st && wrs.size() >= 2) begin
      chk({tag, ".store_repair"}, 256'(wrs[1].rep), 256'(0));
      chk({tag, ".store_addr"}, 256'(wrs[1].addr), 256'(a));
      chk({tag, ".store_data"}, 256'(wrs[1].wd), 256'(sd));
      chk({tag, ".store_rd_zero"}, 256'(wrs[1].rd), 256'(0));
      chk({tag, ".store_follows_fill"}, 256'(wrs[1].k), 256'(wrs[0].k + 1));
    end
    chk({tag, ".busy_ready"}, 256'(busy_bad), 256'(0));
    chk({tag, ".cache_idle_zero"}, 256'(cache_bad), 256'(0));
    chk({tag, ".stall_stable"}, 256'(stall_bad), 256'(0));
  endtask

  initial begin
    logic [31:0] a, sd;
    bit st;
    int sw, sn, rd;
    rst_vec = 256'(1) << (OVW - 1);
    bus.miss_valid = 1'b0; bus.miss_addr = '0; bus.miss_is_store = 1'b0;
    bus.miss_store_data = '0; bus.mem_req_ready = 1'b1; bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data = '0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", out_vec(), rst_vec);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_outputs", out_vec(), rst_vec);

    // Load miss with known memory contents.
    mem[32'h1230] = 32'h11111111; mem[32'h1234] = 32'h22222222;
    mem[32'h1238] = 32'h33333333; mem[32'h123C] = 32'h44444444;
    do_miss(32'h1234, 0, 0, -1, 0, 1, 0, 0, 0, -1);
    check_miss("t1", 32'h1234, 0, 0, 0, 1);
    if (wrs.size() >= 1)
      chk("t1.fill_const", 256'(wrs[0].rd), 256'(128'h44444444_33333333_22222222_11111111));

    do_miss(32'h2008, 1, 32'hDEADBEEF, -1, 0, 1, 0, 0, 0, -1);
    check_miss("t2", 32'h2008, 1, 32'hDEADBEEF, 0, 1);

    // Request stall on word 2 and slow responses.
    do_miss(32'h3004, 0, 0, 2, 3, 5, 0, 0, 0, -1);
    check_miss("t3", 32'h3004, 0, 0, 3, 5);

    // Second miss held high while busy, spurious response during REQ.
    do_miss(32'h4010, 0, 0, -1, 0, 1, 1, 1, 32'h5020, -1);
    check_miss("t4a", 32'h4010, 0, 0, 0, 1);
    do_miss(32'h5020, 1, 32'hCAFEF00D, -1, 0, 1, 0, 0, 0, -1);
    chk("t4.accept_gap", 256'(acc_wait), 256'(1));
    check_miss("t4b", 32'h5020, 1, 32'hCAFEF00D, 0, 1);

    // Reset during the response wait of word 1.
    do_miss(32'h6000, 1, 32'h0BADF00D, -1, 0, 3, 0, 0, 0, 1);
    #1;
    chk("t5.aborted", 256'(aborted), 256'(1));
    chk("t5.async_outputs", out_vec(), rst_vec);
    chk("t5.no_write", 256'(wrs.size()), 256'(0));
    bus.miss_valid = 1'b0; bus.mem_resp_valid = 1'b0; bus.mem_req_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5.post_reset", out_vec(), rst_vec);
    do_miss(32'h7000, 0, 0, -1, 0, 1, 0, 0, 0, -1);
    check_miss("t5b", 32'h7000, 0, 0, 0, 1);

    // Back-to-back load misses.
    do_miss(32'h8000, 0, 0, -1, 0, 1, 0, 1, 32'h9014, -1);
    check_miss("t6a", 32'h8000, 0, 0, 0, 1);
    do_miss(32'h9014, 0, 0, -1, 0, 1, 0, 0, 0, -1);
    chk("t6.accept_gap", 256'(acc_wait), 256'(1));
    check_miss("t6b", 32'h9014, 0, 0, 0, 1);

    for (int i = 0; i < 10; i++) begin
      a  = $urandom;
      st = 1'($urandom_range(0, 1));
      sd = $urandom;
      sw = $urandom_range(0, W - 1);
      sn = $urandom_range(0, 3);
      rd = $urandom_range(1, 4);
      do_miss(a, st, sd, sw, sn, rd, 1'($urandom_range(0, 1)), 0, 0, -1);
      check_miss("rnd", a, st, sd, sn, rd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
